// File: rtl/hazard_ctrl.sv
// Hazard unit for the five-stage MIPS pipeline: forwarding selects, load-use/branch stalls, multi-cycle EX sequencing.
// Optional stalled-cycle statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       MultStartE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       FlushE,
   output logic       MultBusy,
   output logic       MultDone
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] StallCount
`endif
);

   localparam int unsigned CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_CYCLES - 2);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_multstall;
   logic             w_mult_done;
   logic             w_mult_busy;
   logic             w_lwstall;
   logic             w_brstall;
   logic             w_stall_fd;

   // EX-stage forwarding: MEM result beats WB result, register 0 never forwards
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       rw_m,
                                          input logic [4:0] wr_m,
                                          input logic       rw_w,
                                          input logic [4:0] wr_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (src != 5'd0 && rw_m && wr_m == src) begin
         sel = 2'b10;
      end else if (src != 5'd0 && rw_w && wr_w == src) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   assign ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
   assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

   assign w_lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
   assign w_brstall = BranchD &&
                      ((RegWriteE && (WriteRegE != 5'd0) &&
                        ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                       (MemtoRegM && (WriteRegM != 5'd0) &&
                        ((WriteRegM == RsD) || (WriteRegM == RtD))));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Multi-cycle sequencer: the start cycle and BUSY cycles with cnt != 0 hold EX
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_multstall = 1'b0;
      w_mult_done = 1'b0;
      w_mult_busy = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MultStartE) begin
               w_multstall = 1'b1;
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         S_BUSY: begin
            w_mult_busy = 1'b1;
            if (r_cnt != '0) begin
               w_multstall = 1'b1;
               w_cnt_nxt   = r_cnt - CNT_W'(1);
            end else begin
               w_mult_done = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Hold beats flush so an instruction held in EX is never turned into a bubble
   assign w_stall_fd = w_lwstall || w_brstall || w_multstall;
   assign StallE     = !reset && w_multstall;
   assign StallF     = !reset && w_stall_fd;
   assign StallD     = !reset && w_stall_fd;
   assign FlushE     = !reset && (w_lwstall || w_brstall) && !w_multstall;
   assign MultBusy   = !reset && w_mult_busy;
   assign MultDone   = !reset && w_mult_done;

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (StallF && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions, negedge monitor pops and compares.
module tb_hazard_ctrl;

   localparam int unsigned MC1 = 4;
   localparam int unsigned MC2 = 2;

   typedef struct packed {
      logic       rst;
      logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
      logic       rwe, rwm, rww, m2re, m2rm, brd, mst;
   } stim_t;

   typedef struct packed {
      logic [1:0]  fae, fbe;
      logic        fad, fbd, sf, sd, se, fe, busy, done;
      logic        se2, busy2, done2;
      logic [31:0] cnt, cnt2;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MultStartE;
   logic [1:0] ForwardAE, ForwardBE, fae2, fbe2;
   logic       ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, MultBusy, MultDone;
   logic       fad2, fbd2, sf2, sd2, se2, fe2, busy2, done2;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count, stall_count2;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t exp_q[$];

   // model state: index of the current cycle within an op (0 = no op in flight)
   int   pos1 = 0, pos2 = 0;
   int   scnt1 = 0, scnt2 = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULT_CYCLES(MC1)) u_dut (
      .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .MultStartE(MultStartE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallF(StallF), .StallD(StallD),
      .StallE(StallE), .FlushE(FlushE), .MultBusy(MultBusy), .MultDone(MultDone)
`ifdef HAZARD_STATS_EN
      , .StallCount(stall_count)
`endif
   );

   hazard_ctrl #(.MULT_CYCLES(MC2)) u_dut2 (
      .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .MultStartE(MultStartE), .ForwardAE(fae2), .ForwardBE(fbe2),
      .ForwardAD(fad2), .ForwardBD(fbd2), .StallF(sf2), .StallD(sd2),
      .StallE(se2), .FlushE(fe2), .MultBusy(busy2), .MultDone(done2)
`ifdef HAZARD_STATS_EN
      , .StallCount(stall_count2)
`endif
   );

   function automatic logic [1:0] m_fwd(input logic [4:0] r, input stim_t s);
      if (r != 0 && s.rwm && s.wrm == r) return 2'b10;
      if (r != 0 && s.rww && s.wrw == r) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic in_pair(input logic [4:0] w, input stim_t s);
      return (w != 0) && (w == s.rsd || w == s.rtd);
   endfunction

   function automatic stim_t idle_stim();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      exp_t e;
      logic lw, br, ms1, ms2;
      int   eff1, eff2;
      reset = s.rst; RsD = s.rsd; RtD = s.rtd; RsE = s.rse; RtE = s.rte;
      WriteRegE = s.wre; WriteRegM = s.wrm; WriteRegW = s.wrw;
      RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww;
      MemtoRegE = s.m2re; MemtoRegM = s.m2rm; BranchD = s.brd; MultStartE = s.mst;

      eff1 = (pos1 == 0 && s.mst) ? 1 : pos1;
      eff2 = (pos2 == 0 && s.mst) ? 1 : pos2;
      lw   = !s.rst && s.m2re && in_pair(s.rte, s);
      br   = !s.rst && s.brd && ((s.rwe && in_pair(s.wre, s)) || (s.m2rm && in_pair(s.wrm, s)));
      ms1  = !s.rst && eff1 >= 1 && eff1 < int'(MC1);
      ms2  = !s.rst && eff2 >= 1 && eff2 < int'(MC2);

      e.fae   = m_fwd(s.rse, s);
      e.fbe   = m_fwd(s.rte, s);
      e.fad   = (s.rsd != 0) && s.rwm && (s.wrm == s.rsd);
      e.fbd   = (s.rtd != 0) && s.rwm && (s.wrm == s.rtd);
      e.sf    = lw | br | ms1;
      e.sd    = e.sf;
      e.se    = ms1;
      e.fe    = (lw | br) & ~ms1;
      e.busy  = !s.rst && eff1 >= 2;
      e.done  = !s.rst && eff1 == int'(MC1);
      e.se2   = ms2;
      e.busy2 = !s.rst && eff2 >= 2;
      e.done2 = !s.rst && eff2 == int'(MC2);
      e.cnt   = 32'(scnt1);
      e.cnt2  = 32'(scnt2);
      exp_q.push_back(e);

      pos1  = (s.rst || eff1 == 0 || eff1 == int'(MC1)) ? 0 : eff1 + 1;
      pos2  = (s.rst || eff2 == 0 || eff2 == int'(MC2)) ? 0 : eff2 + 1;
      scnt1 = s.rst ? 0 : scnt1 + int'(lw | br | ms1);
      scnt2 = s.rst ? 0 : scnt2 + int'(lw | br | ms2);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   // monitor: outputs are combinational, so each cycle presents one response
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ForwardAE", 32'(ForwardAE), 32'(e.fae));
            chk("ForwardBE", 32'(ForwardBE), 32'(e.fbe));
            chk("ForwardAD", 32'(ForwardAD), 32'(e.fad));
            chk("ForwardBD", 32'(ForwardBD), 32'(e.fbd));
            chk("StallF",    32'(StallF),    32'(e.sf));
            chk("StallD",    32'(StallD),    32'(e.sd));
            chk("StallE",    32'(StallE),    32'(e.se));
            chk("FlushE",    32'(FlushE),    32'(e.fe));
            chk("MultBusy",  32'(MultBusy),  32'(e.busy));
            chk("MultDone",  32'(MultDone),  32'(e.done));
            chk("StallE_mc2",   32'(se2),   32'(e.se2));
            chk("MultBusy_mc2", 32'(busy2), 32'(e.busy2));
            chk("MultDone_mc2", 32'(done2), 32'(e.done2));
`ifdef HAZARD_STATS_EN
            chk("StallCount",     stall_count,  e.cnt);
            chk("StallCount_mc2", stall_count2, e.cnt2);
`endif
         end
      end
   end

   initial begin
      stim_t s;
      reset = 1'b1; RsD = '0; RtD = '0; RsE = '0; RtE = '0;
      WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0; MultStartE = 1'b0;
      @(posedge clk);
      #1;

      s = idle_stim(); s.rst = 1'b1; s.mst = 1'b1; s.m2re = 1'b1; s.rte = 5'd3; s.rsd = 5'd3;
      drive(s); drive(s);

      // EX->EX forwarding, MEM priority over WB
      s = idle_stim(); s.rwm = 1'b1; s.wrm = 5'd8; s.rse = 5'd8;
      drive(s);
      s.rww = 1'b1; s.wrw = 5'd8;
      drive(s);
      s.rwm = 1'b0;
      drive(s);

      // load-use for one cycle
      s = idle_stim(); s.m2re = 1'b1; s.rte = 5'd9; s.rsd = 5'd9;
      drive(s);
      s = idle_stim(); drive(s);

      // multi-cycle op with MultStartE held high (back-to-back ops)
      s = idle_stim(); s.mst = 1'b1;
      for (int i = 0; i < 9; i++) drive(s);
      s = idle_stim(); drive(s); drive(s);

      // load-use concurrent with multi-cycle op
      s = idle_stim(); s.mst = 1'b1; s.m2re = 1'b1; s.rte = 5'd9; s.rtd = 5'd9;
      drive(s);
      s.mst = 1'b0;
      for (int i = 0; i < 5; i++) drive(s);

      // reset in the 2nd BUSY cycle
      s = idle_stim(); s.mst = 1'b1; drive(s);
      s.mst = 1'b0; drive(s);
      s.rst = 1'b1; drive(s);
      s.rst = 1'b0; drive(s); drive(s);

      // register 0 never forwards or stalls
      s = idle_stim(); s.rwm = 1'b1; s.wrm = 5'd0; s.rse = 5'd0; s.rww = 1'b1;
      s.m2re = 1'b1; s.brd = 1'b1; s.rwe = 1'b1;
      drive(s);

      // five separated load-use stalls after reset
      s = idle_stim(); s.rst = 1'b1; drive(s);
      for (int i = 0; i < 5; i++) begin
         s = idle_stim(); s.m2re = 1'b1; s.rte = 5'd12; s.rtd = 5'd12; drive(s);
         s = idle_stim(); drive(s);
      end

      // randomized traffic on a small register set to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         s.rst  = ($urandom_range(0, 99) < 2);
         s.rsd  = 5'($urandom_range(0, 3));
         s.rtd  = 5'($urandom_range(0, 3));
         s.rse  = 5'($urandom_range(0, 3));
         s.rte  = 5'($urandom_range(0, 3));
         s.wre  = 5'($urandom_range(0, 3));
         s.wrm  = 5'($urandom_range(0, 3));
         s.wrw  = 5'($urandom_range(0, 3));
         s.rwe  = 1'($urandom_range(0, 1));
         s.rwm  = 1'($urandom_range(0, 1));
         s.rww  = 1'($urandom_range(0, 1));
         s.m2re = ($urandom_range(0, 3) == 0);
         s.m2rm = ($urandom_range(0, 3) == 0);
         s.brd  = ($urandom_range(0, 3) == 0);
         s.mst  = ($urandom_range(0, 5) == 0);
         drive(s);
      end

      s = idle_stim(); drive(s);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
